sram_queue_ctrl: RTL and testbench

SRAM_QUEUE_CTRL -- requirements
Module: sram_queue_ctrl

---
 rtl/sram_queue_pkg.sv | 22 ++
 rtl/sram_queue_outbuf.sv | 63 ++++++
 rtl/sram_queue_ctrl.sv | 119 +++++++++++
 tb/tb_sram_queue_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_queue_pkg.sv
// Shared defaults and SRAM port-bundle types for the SRAM-backed queue.
// The control bundles carry only the 1-bit strobes, so they fit any WIDTH/AW.
package sram_queue_pkg;

    localparam int WIDTH_DEF = 64;
    localparam int DEPTH_DEF = 17;
    localparam int AW_DEF    = 5;

    typedef struct packed {
        logic csb;
        logic oeb;
    } sram_rd_ctl_t;

    typedef struct packed {
        logic csb;
        logic web;
    } sram_wr_ctl_t;

    localparam sram_rd_ctl_t RD_IDLE = '{csb: 1'b1, oeb: 1'b0};
    localparam sram_wr_ctl_t WR_IDLE = '{csb: 1'b1, web: 1'b1};

endpackage

// File: rtl/sram_queue_outbuf.sv
// Two-entry output stage (head + skid) fed by SRAM read data or the bypass path.
// The parent decides when to push from cnt_o; pushing into a full stage never happens.
module sram_queue_outbuf
    import sram_queue_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [1:0]       cnt_o
);

    logic [1:0]       cnt_q;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] skid_q;
    logic             pop_fire;

    assign valid_o  = (cnt_q != 2'd0);
    assign data_o   = head_q;
    assign cnt_o    = cnt_q;
    assign pop_fire = pop_i & valid_o;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= 2'd0;
        end else begin
            case ({push_i, pop_fire})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // NOTE: payload registers are not reset; cnt_q alone decides whether they hold valid data.
    always_ff @(posedge clock) begin
        if (pop_fire) begin
            if (push_i) begin
                if (cnt_q == 2'd1) begin
                    head_q <= push_data_i;
                end else begin
                    head_q <= skid_q;
                    skid_q <= push_data_i;
                end
            end else begin
                head_q <= skid_q;
            end
        end else if (push_i) begin
            if (cnt_q == 2'd0) begin
                head_q <= push_data_i;
            end else begin
                skid_q <= push_data_i;
            end
        end
    end

endmodule

// File: rtl/sram_queue_ctrl.sv
// Ready/valid queue backed by a 1R1W registered-output SRAM plus a 2-entry output stage.
// Define SRAM_QUEUE_FLOW_EN to let an enqueue into an empty queue bypass the SRAM.
module sram_queue_ctrl
    import sram_queue_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [WIDTH-1:0] enq_bits,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [WIDTH-1:0] deq_bits,
    output logic [AW-1:0]    count,
    output logic [AW-1:0]    sram_A1,
    output logic             sram_CSB1,
    output logic             sram_OEB1,
    input  logic [WIDTH-1:0] sram_O1,
    output logic [AW-1:0]    sram_A2,
    output logic             sram_CSB2,
    output logic             sram_WEB2,
    output logic [WIDTH-1:0] sram_I2
);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    sram_cnt_q, sram_cnt_d;
    logic             rd_pend_q;
    logic [1:0]       out_cnt;
    logic             enq_fire, deq_fire, wr_en, rd_en, buf_push;
    logic [WIDTH-1:0] buf_data;
    sram_rd_ctl_t     rd_ctl;
    sram_wr_ctl_t     wr_ctl;

    assign enq_ready = ~reset & (sram_cnt_q < AW'(DEPTH));
    assign enq_fire  = enq_valid & enq_ready;
    assign deq_fire  = deq_valid & deq_ready;

    // Read only what was written on an earlier edge, and only if the output stage will have room.
    assign rd_en = (sram_cnt_q != '0) &&
                   ((3'(out_cnt) + 3'(rd_pend_q)) < (3'd2 + 3'(deq_fire)));

`ifdef SRAM_QUEUE_FLOW_EN
    logic bypass;
    assign bypass   = enq_fire && (sram_cnt_q == '0) && !rd_pend_q &&
                      (3'(out_cnt) < (3'd2 + 3'(deq_fire)));
    assign wr_en    = enq_fire & ~bypass;
    assign buf_push = rd_pend_q | bypass;
    assign buf_data = rd_pend_q ? sram_O1 : enq_bits;
`else
    assign wr_en    = enq_fire;
    assign buf_push = rd_pend_q;
    assign buf_data = sram_O1;
`endif

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        rd_ctl     = RD_IDLE;
        wr_ctl     = WR_IDLE;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        sram_cnt_d = sram_cnt_q;
        if (rd_en) begin
            rd_ctl.csb = 1'b0;
            rd_ptr_d   = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
        end
        if (wr_en) begin
            wr_ctl.csb = 1'b0;
            wr_ctl.web = 1'b0;
            wr_ptr_d   = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   sram_cnt_d = sram_cnt_q + AW'(1);
            2'b01:   sram_cnt_d = sram_cnt_q - AW'(1);
            default: sram_cnt_d = sram_cnt_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            sram_cnt_q <= '0;
            rd_pend_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            sram_cnt_q <= sram_cnt_d;
            rd_pend_q  <= rd_en;
        end
    end

    sram_queue_outbuf #(
        .WIDTH(WIDTH)
    ) u_outbuf (
        .clock      (clock),
        .reset      (reset),
        .push_i     (buf_push),
        .push_data_i(buf_data),
        .pop_i      (deq_ready),
        .valid_o    (deq_valid),
        .data_o     (deq_bits),
        .cnt_o      (out_cnt)
    );

    assign count     = sram_cnt_q + AW'(rd_pend_q) + AW'(out_cnt);
    assign sram_A1   = rd_ptr_q;
    assign sram_CSB1 = rd_ctl.csb;
    assign sram_OEB1 = rd_ctl.oeb;
    assign sram_A2   = wr_ptr_q;
    assign sram_CSB2 = wr_ctl.csb;
    assign sram_WEB2 = wr_ctl.web;
    assign sram_I2   = enq_bits;

endmodule

// File: tb/tb_sram_queue_ctrl.sv
// Directed self-checking bench for sram_queue_ctrl with a behavioural registered-output SRAM.
// Build with SRAM_QUEUE_FLOW_EN defined to check the bypass latency instead.
module tb_sram_queue_ctrl;

    localparam int WIDTH = 64;
    localparam int DEPTH = 17;
    localparam int AW    = 5;
`ifdef SRAM_QUEUE_FLOW_EN
    localparam int EXP_LAT = 1;
`else
    localparam int EXP_LAT = 3;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             enq_valid, enq_ready, deq_valid, deq_ready;
    logic [WIDTH-1:0] enq_bits, deq_bits, sram_O1, sram_I2;
    logic [AW-1:0]    count, sram_A1, sram_A2;
    logic             sram_CSB1, sram_OEB1, sram_CSB2, sram_WEB2;

    always #5 clock = ~clock;

    sram_queue_ctrl #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .AW   (AW)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .enq_valid(enq_valid),
        .enq_ready(enq_ready),
        .enq_bits (enq_bits),
        .deq_valid(deq_valid),
        .deq_ready(deq_ready),
        .deq_bits (deq_bits),
        .count    (count),
        .sram_A1  (sram_A1),
        .sram_CSB1(sram_CSB1),
        .sram_OEB1(sram_OEB1),
        .sram_O1  (sram_O1),
        .sram_A2  (sram_A2),
        .sram_CSB2(sram_CSB2),
        .sram_WEB2(sram_WEB2),
        .sram_I2  (sram_I2)
    );

    // Registered-output SRAM: read data appears the cycle after the read edge.
    logic [WIDTH-1:0] mem [0:31];
    always @(posedge clock) begin
        if (!sram_CSB2 && !sram_WEB2) mem[sram_A2] <= sram_I2;
        if (!sram_CSB1) sram_O1 <= mem[sram_A1];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard of accepted words plus SRAM address sanity, sampled mid-cycle.
    logic [63:0] sb_q[$];
    always @(negedge clock) begin
        if (!reset) begin
            if (!sram_CSB2 && !sram_WEB2) check("wr_addr_range", 64'(sram_A2 < AW'(DEPTH)), 64'd1);
            if (!sram_CSB1) check("rd_addr_range", 64'(sram_A1 < AW'(DEPTH)), 64'd1);
            if (!sram_CSB1 && !sram_CSB2 && !sram_WEB2)
                check("rd_wr_same_addr", 64'(sram_A1 != sram_A2), 64'd1);
            if (deq_valid && deq_ready) begin
                check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) check("sb_data", deq_bits, sb_q.pop_front());
            end
            if (enq_valid && enq_ready) sb_q.push_back(enq_bits);
        end
    end

    task automatic push_word(input logic [63:0] d);
        int b = 0;
        enq_valid = 1'b1;
        enq_bits  = d;
        while (!enq_ready && b < 20) begin
            tick();
            b++;
        end
        check("push_ready", 64'(enq_ready), 64'd1);
        tick();
    endtask

    task automatic drain(input string tag);
        int b = 0;
        deq_ready = 1'b1;
        while (count != '0 && b < 60) begin
            tick();
            b++;
        end
        check(tag, 64'(count), 64'd0);
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        deq_ready = 1'b0;
    endtask

    initial begin
        int lat, sent, fires, first, last, b;
        logic prev_stall;
        logic [63:0] prev_bits;

        enq_valid = 1'b0;
        enq_bits  = '0;
        deq_ready = 1'b0;
        #3;
        check("rst_count", 64'(count), 64'd0);
        check("rst_deq_valid", 64'(deq_valid), 64'd0);
        check("rst_csb1", 64'(sram_CSB1), 64'd1);
        check("rst_csb2", 64'(sram_CSB2), 64'd1);
        check("rst_web2", 64'(sram_WEB2), 64'd1);
        check("oeb1_low", 64'(sram_OEB1), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("ready_after_rst", 64'(enq_ready), 64'd1);

        // Latency into an empty queue
        enq_valid = 1'b1;
        enq_bits  = 64'hA5A5;
        deq_ready = 1'b1;
        tick();
        enq_valid = 1'b0;
        lat = 1;
        while (!deq_valid && lat < 10) begin
            tick();
            lat++;
        end
        check("latency", 64'(lat), 64'(EXP_LAT));
        check("latency_bits", deq_bits, 64'hA5A5);
        tick();
        deq_ready = 1'b0;
        check("latency_empty", 64'(count), 64'd0);

        // Fill to DEPTH+2, then a dequeue while full
        for (int i = 1; i <= 19; i++) push_word(64'(i));
        check("full_ready", 64'(enq_ready), 64'd0);
        check("full_count", 64'(count), 64'd19);
        enq_bits  = 64'd20;
        deq_ready = 1'b1;
        #1;
        check("full_deq_same_cycle", 64'(enq_ready), 64'd0);
        tick();
        check("full_ready_next", 64'(enq_ready), 64'd1);
        check("full_count_next", 64'(count), 64'd18);
        tick();
        enq_valid = 1'b0;
        drain("full_drain_count");

        // Streaming: one dequeue per cycle, pointers wrap twice
        sent = 0; fires = 0; first = -1; last = -1;
        enq_valid = 1'b1;
        enq_bits  = 64'd100;
        deq_ready = 1'b1;
        for (int c = 0; c < 80 && fires < 40; c++) begin
            @(negedge clock);
            if (enq_valid && enq_ready) sent++;
            if (deq_valid && deq_ready) begin
                fires++;
                if (first < 0) first = c;
                last = c;
            end
            tick();
            enq_valid = (sent < 40);
            enq_bits  = 64'(100 + sent);
        end
        enq_valid = 1'b0;
        check("stream_fires", 64'(fires), 64'd40);
        check("stream_span", 64'(last - first + 1), 64'd40);
        check("stream_count", 64'(count), 64'd0);
        check("stream_sb", 64'(sb_q.size()), 64'd0);
        deq_ready = 1'b0;

        // Random consumer stalls
        sent = 0;
        prev_stall = 1'b0;
        prev_bits  = '0;
        b = 0;
        while (!(sent == 12 && count == '0) && b < 300) begin
            enq_valid = (sent < 12);
            enq_bits  = 64'(32'h200 + sent);
            deq_ready = 1'($urandom_range(0, 1));
            @(negedge clock);
            if (prev_stall) begin
                check("stall_valid", 64'(deq_valid), 64'd1);
                check("stall_bits", deq_bits, prev_bits);
            end
            prev_stall = deq_valid && !deq_ready;
            prev_bits  = deq_bits;
            if (enq_valid && enq_ready) sent++;
            tick();
            b++;
        end
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        check("random_sent", 64'(sent), 64'd12);
        check("random_count", 64'(count), 64'd0);
        check("random_sb", 64'(sb_q.size()), 64'd0);

        // Reset mid-operation with a read in flight
        for (int i = 0; i < 7; i++) push_word(64'(32'h300 + i));
        enq_bits  = 64'h307;
        deq_ready = 1'b1;
        #1;
        check("pre_rst_read_issued", 64'(sram_CSB1), 64'd0);
        tick();
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        check("pre_rst_count", 64'(count), 64'd7);
        reset     = 1'b1;
        enq_valid = 1'b1;
        enq_bits  = 64'hBAD;
        #1;
        check("mid_rst_count", 64'(count), 64'd0);
        check("mid_rst_deq_valid", 64'(deq_valid), 64'd0);
        check("mid_rst_csb1", 64'(sram_CSB1), 64'd1);
        check("mid_rst_csb2", 64'(sram_CSB2), 64'd1);
        check("mid_rst_web2", 64'(sram_WEB2), 64'd1);
        sb_q.delete();
        tick();
        enq_valid = 1'b0;
        reset     = 1'b0;
        #1;
        check("post_rst_ready", 64'(enq_ready), 64'd1);
        check("post_rst_count", 64'(count), 64'd0);
        enq_valid = 1'b1;
        enq_bits  = 64'h1;
        deq_ready = 1'b1;
        tick();
        enq_valid = 1'b0;
        b = 0;
        while (!deq_valid && b < 10) begin
            tick();
            b++;
        end
        check("post_rst_valid", 64'(deq_valid), 64'd1);
        check("post_rst_first", deq_bits, 64'h1);
        tick();
        deq_ready = 1'b0;
        check("post_rst_empty", 64'(count), 64'd0);
        check("post_rst_sb", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
